iterative_muldiv_unit: RTL and testbench

//  Multi-cycle RV32M multiply/divide engine beside the ALU in the multicycle datapath.

---
 rtl/iterative_muldiv_unit_if.sv | 24 ++
 rtl/iterative_muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_iterative_muldiv_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/iterative_muldiv_unit_if.sv
// Start/busy/done request bus between the multicycle controller and the mul/div engine.
// The controller drives the request side and consumes the registered result.
interface iterative_muldiv_unit_if #(
    parameter int WL = 32
);
    logic          start;
    logic [2:0]    op;
    logic [WL-1:0] operand1;
    logic [WL-1:0] operand2;
    logic          flush;
    logic          busy;
    logic          done;
    logic [WL-1:0] result;

    modport master (
        output start, op, operand1, operand2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand1, operand2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/iterative_muldiv_unit.sv
// RV32M iterative multiply/divide: one shift-add or restoring shift-subtract step per clock,
// operating on magnitudes with the sign fixed up on the last step.
module iterative_muldiv_unit #(
    parameter int WL = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    iterative_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WL);
    localparam logic [WL-1:0] MIN_NEG = {1'b1, {(WL-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [WL-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [WL-1:0] res_q, res_d, spec_val_q, spec_val_d;
    logic          neg_q, neg_d, spec_q, spec_d;

    // Accept-time decode of the incoming request
    logic          is_div, a_sgn_op, b_sgn_op, a_neg, b_neg, ovf, acc_neg, acc_spec;
    logic [WL-1:0] a_mag, b_mag, acc_spec_val;

    always_comb begin
        is_div   = bus.op[2];
        a_sgn_op = is_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10);
        b_sgn_op = is_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
        a_neg    = a_sgn_op & bus.operand1[WL-1];
        b_neg    = b_sgn_op & bus.operand2[WL-1];
        a_mag    = a_neg ? -bus.operand1 : bus.operand1;
        b_mag    = b_neg ? -bus.operand2 : bus.operand2;
        // Remainder follows the dividend's sign; everything else uses sign(a)^sign(b)
        acc_neg  = (is_div && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
        ovf      = ~bus.op[0] && (bus.operand1 == MIN_NEG) && (bus.operand2 == '1);
        acc_spec = is_div && ((bus.operand2 == '0) || ovf);
        if (bus.operand2 == '0) begin
            acc_spec_val = bus.op[1] ? bus.operand1 : '1;
        end else begin
            acc_spec_val = bus.op[1] ? '0 : bus.operand1;
        end
    end

    // One iteration of the datapath; hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}
    logic [WL:0]     mul_sum, r_sh;
    logic [WL-1:0]   r_diff, step_hi, step_lo, div_raw, final_res;
    logic [2*WL-1:0] prod, prod_sgn;
    logic            ge;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        r_sh    = {hi_q, lo_q[WL-1]};
        ge      = r_sh >= {1'b0, b_q};
        r_diff  = r_sh[WL-1:0] - b_q;
        if (op_q[2]) begin
            step_hi = ge ? r_diff : r_sh[WL-1:0];
            step_lo = {lo_q[WL-2:0], ge};
        end else begin
            step_hi = mul_sum[WL:1];
            step_lo = {mul_sum[0], lo_q[WL-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_sgn = neg_q ? -prod : prod;
        div_raw  = op_q[1] ? step_hi : step_lo;
        if (spec_q) begin
            final_res = spec_val_q;
        end else if (op_q[2]) begin
            final_res = neg_q ? -div_raw : div_raw;
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? prod_sgn[WL-1:0] : prod_sgn[2*WL-1:WL];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        b_d        = b_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        res_d      = res_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (!bus.flush && bus.start) begin
                    state_d    = CALC;
                    cnt_d      = CW'(WL - 1);
                    op_d       = bus.op;
                    hi_d       = '0;
                    lo_d       = a_mag;
                    b_d        = b_mag;
                    neg_d      = acc_neg;
                    spec_d     = acc_spec;
                    spec_val_d = acc_spec_val;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        res_d   = final_res;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            b_q        <= b_d;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            res_q      <= res_d;
        end
    end

    assign bus.busy   = (state_q == CALC);
    assign bus.done   = (state_q == DONE);
    assign bus.result = res_q;
endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Self-checking bench for iterative_muldiv_unit (WL=32): directed vectors, handshake corner cases,
// and random operations compared against a plain-arithmetic RV32M model.
module tb_iterative_muldiv_unit;
    localparam int WL = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    iterative_muldiv_unit_if #(.WL(WL)) bus ();

    iterative_muldiv_unit #(.WL(WL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub, q;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        q   = 0;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                q = sa / sb; return q[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = ua / ub; return q[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                q = ua % ub; return q[31:0];
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle (or after a timeout).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat, output int busy_cnt);
        bus.start    = 1'b1;
        bus.op       = o;
        bus.operand1 = a;
        bus.operand2 = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat       = -1;
        busy_cnt  = 0;
        r         = '0;
        for (int k = 1; k <= 200; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = k - 1;
                r   = bus.result;
                break;
            end
            @(negedge clk);
        end
    endtask

    logic [31:0] r, r_prev, exp;
    int          lat, bcnt, done_seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
        vecs[7]  = '{3'd5, 32'd100,        32'd7,          32'd14};
        vecs[8]  = '{3'd7, 32'd100,        32'd7,          32'd2};
        vecs[9]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[10] = '{3'd7, 32'd5,          32'd0,          32'd5};
        vecs[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        vecs[13] = '{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF};

        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.operand1 = '0; bus.operand2 = '0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",   32'(bus.busy), 32'd0);
        check("reset_done",   32'(bus.done), 32'd0);
        check("reset_result", bus.result,    32'd0);

        // Directed vectors: value, fixed latency, busy duration, single-cycle done
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, bcnt);
            check($sformatf("vec%0d_op%0d_result", i, vecs[i].op), r, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd32);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd32);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
        end

        // Flush during CALC cycle 10
        run_op(3'd0, 32'd3, 32'd5, r_prev, lat, bcnt);
        check("pre_flush_result", r_prev, 32'd15);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd5; bus.operand1 = 32'd1000; bus.operand2 = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        check("flush_no_done", 32'(done_seen), 32'd0);
        check("flush_result_kept", bus.result, r_prev);

        // Flush in IDLE suppresses a simultaneous start
        bus.start = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_idle_start_busy", 32'(bus.busy), 32'd0);

        // Reset at cycle 5 of an operation
        bus.start = 1'b1; bus.op = 3'd1; bus.operand1 = 32'h1234_5678; bus.operand2 = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_result", bus.result, 32'd0);
        check("midrst_busy",   32'(bus.busy), 32'd0);
        check("midrst_done",   32'(bus.done), 32'd0);
        run_op(3'd6, 32'd100, 32'd7, r, lat, bcnt);
        check("post_rst_result", r, 32'd2);
        check("post_rst_latency", 32'(lat), 32'd32);
        @(negedge clk);

        // Inputs churn while busy; then back-to-back start in the DONE cycle
        bus.start = 1'b1; bus.op = 3'd5; bus.operand1 = 32'd100; bus.operand2 = 32'd7;
        @(negedge clk);
        lat = -1; r = '0;
        for (int k = 1; k <= 200; k++) begin
            if (bus.done) begin
                lat = k - 1;
                r   = bus.result;
                break;
            end
            bus.start    = 1'($urandom_range(0, 1));
            bus.op       = 3'($urandom_range(0, 7));
            bus.operand1 = $urandom;
            bus.operand2 = $urandom;
            @(negedge clk);
        end
        check("churn_result", r, 32'd14);
        check("churn_latency", 32'(lat), 32'd32);
        run_op(3'd0, 32'd6, 32'd7, r, lat, bcnt);
        check("b2b_result", r, 32'd42);
        check("b2b_latency", 32'(lat), 32'd32);
        @(negedge clk);

        // Random operations against the reference model
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            exp = model(rop, ra, rb);
            run_op(rop, ra, rb, r, lat, bcnt);
            check($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), r, exp);
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'd32);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
